// File: rtl/rf_wb_arbiter_pkg.sv
// Shared constants and helpers for the register-file writeback arbiter.
//   RF_XLEN  : default data width
//   RF_AW    : default register index width
//   REG_ZERO : index of the hard-wired zero register (x0)
//   rr_next  : round-robin successor of an index, wrapping at n
package rf_wb_arbiter_pkg;

  localparam int         RF_XLEN  = 32;
  localparam int         RF_AW    = 5;
  localparam logic [4:0] REG_ZERO = 5'd0;

  // Explicit wrap so non-power-of-two requester counts never land on an
  // index that does not exist.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Writeback request bundle between the writeback sources and the arbiter.
//   req_valid : per-requester write pending
//   req_rd    : per-requester destination index, requester i at [i*AW +: AW]
//   req_data  : per-requester write data, requester i at [i*XLEN +: XLEN]
//   req_ready : one-hot grant back to the requesters
// master = requester side, slave = arbiter side.
interface rf_wb_arbiter_if #(
  parameter int N_REQ = 3,
  parameter int XLEN  = 32,
  parameter int AW    = 5
);

  logic [N_REQ-1:0]      req_valid;
  logic [N_REQ*AW-1:0]   req_rd;
  logic [N_REQ*XLEN-1:0] req_data;
  logic [N_REQ-1:0]      req_ready;

  modport master (output req_valid, output req_rd, output req_data, input req_ready);
  modport slave  (input req_valid, input req_rd, input req_data, output req_ready);

endinterface

// File: rtl/rf_wb_arbiter_rr_arbiter.sv
// Combinational round-robin picker.
//   req       : request vector
//   ptr       : index with highest priority this cycle
//   gnt       : one-hot grant (first set bit at or after ptr, wrapping)
//   gnt_idx   : binary index of the granted requester
//   gnt_valid : any request was found
module rf_wb_arbiter_rr_arbiter #(
  parameter int N  = 3,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          gnt_valid
);

  int            cand;
  logic [IW-1:0] cidx;

  always_comb begin
    gnt       = '0;
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    cand      = 0;
    cidx      = '0;
    // Walk the requesters in priority order ptr, ptr+1, ... and keep the first hit.
    for (int k = 0; k < N; k++) begin
      cand = int'(ptr) + k;
      if (cand >= N) cand = cand - N;
      cidx = IW'(cand);
      if (!gnt_valid && req[cidx]) begin
        gnt_valid = 1'b1;
        gnt_idx   = cidx;
        gnt[cidx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Shares the single register-file write port among N_REQ writeback sources
// with round-robin arbitration and a one-entry registered output, and bypasses
// the in-flight write onto both read ports.
//   clk, rst_n           : clock, asynchronous active-low reset
//   hold                 : freeze arbitration this cycle (no grant, pointer kept)
//   wb                   : request bundle (valid / rd / data in, one-hot ready out)
//   rf_wEn/rf_rd/rf_write_data : registered regfile write port
//   rs1, rs2             : read indices (passed to the regfile by the datapath)
//   rf_rdata1/2          : raw regfile read data
//   rdata1/2             : read data with the pending write forwarded
module rf_wb_arbiter
  import rf_wb_arbiter_pkg::*;
#(
  parameter int N_REQ = 3,
  parameter int XLEN  = RF_XLEN,
  parameter int AW    = RF_AW
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            hold,
  rf_wb_arbiter_if.slave  wb,
  output logic            rf_wEn,
  output logic [AW-1:0]   rf_rd,
  output logic [XLEN-1:0] rf_write_data,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  input  logic [XLEN-1:0] rf_rdata1,
  input  logic [XLEN-1:0] rf_rdata2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2
);

  localparam int            IW      = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [AW-1:0] RD_ZERO = AW'(REG_ZERO);

  logic [IW-1:0]   rr_ptr_reg, rr_ptr_next;
  logic            run_reg;
  logic            wen_reg, wen_next;
  logic [AW-1:0]   rd_reg, rd_next;
  logic [XLEN-1:0] data_reg, data_next;

  logic [N_REQ-1:0] gnt;
  logic [IW-1:0]    gnt_idx;
  logic             gnt_valid;
  logic             active;
  logic             xfer;

  logic [AW-1:0]   rd_arr   [N_REQ];
  logic [XLEN-1:0] data_arr [N_REQ];
  logic [AW-1:0]   sel_rd;
  logic [XLEN-1:0] sel_data;

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign rd_arr[gi]   = wb.req_rd[gi*AW +: AW];
      assign data_arr[gi] = wb.req_data[gi*XLEN +: XLEN];
    end
  endgenerate

  rf_wb_arbiter_rr_arbiter #(.N(N_REQ), .IW(IW)) u_arb (
    .req       (wb.req_valid),
    .ptr       (rr_ptr_reg),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid)
  );

  // run_reg is cleared asynchronously by reset and only set by the first
  // clock edge afterwards, so no grant appears between reset release and
  // that edge.
  assign active       = run_reg && !hold;
  assign wb.req_ready = active ? gnt : '0;
  assign xfer         = active && gnt_valid;

  assign sel_rd   = rd_arr[gnt_idx];
  assign sel_data = data_arr[gnt_idx];

  always_comb begin
    rr_ptr_next = rr_ptr_reg;
    wen_next    = 1'b0;
    rd_next     = rd_reg;
    data_next   = data_reg;
    if (xfer) begin
      rr_ptr_next = IW'(rr_next(int'(gnt_idx), N_REQ));
      // A write to x0 is accepted but never reaches the regfile.
      wen_next    = (sel_rd != RD_ZERO);
      rd_next     = sel_rd;
      data_next   = sel_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_reg <= '0;
      run_reg    <= 1'b0;
      wen_reg    <= 1'b0;
      rd_reg     <= '0;
      data_reg   <= '0;
    end else begin
      rr_ptr_reg <= rr_ptr_next;
      run_reg    <= 1'b1;
      wen_reg    <= wen_next;
      rd_reg     <= rd_next;
      data_reg   <= data_next;
    end
  end

  assign rf_wEn        = wen_reg;
  assign rf_rd         = rd_reg;
  assign rf_write_data = data_reg;

  // Forward the write being committed this cycle; x0 always reads raw (zero).
  assign rdata1 = (wen_reg && rd_reg == rs1 && rs1 != RD_ZERO) ? data_reg : rf_rdata1;
  assign rdata2 = (wen_reg && rd_reg == rs2 && rs2 != RD_ZERO) ? data_reg : rf_rdata2;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
module tb_rf_wb_arbiter;

  localparam int N  = 3;
  localparam int XW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          hold = 1'b0;
  logic [AW-1:0] rs1 = '0;
  logic [AW-1:0] rs2 = '0;
  logic [XW-1:0] rf_rdata1 = '0;
  logic [XW-1:0] rf_rdata2 = '0;
  logic          rf_wEn;
  logic [AW-1:0] rf_rd;
  logic [XW-1:0] rf_write_data;
  logic [XW-1:0] rdata1;
  logic [XW-1:0] rdata2;

  rf_wb_arbiter_if #(.N_REQ(N), .XLEN(XW), .AW(AW)) wb ();

  rf_wb_arbiter #(.N_REQ(N), .XLEN(XW), .AW(AW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .hold          (hold),
    .wb            (wb),
    .rf_wEn        (rf_wEn),
    .rf_rd         (rf_rd),
    .rf_write_data (rf_write_data),
    .rs1           (rs1),
    .rs2           (rs2),
    .rf_rdata1     (rf_rdata1),
    .rf_rdata2     (rf_rdata2),
    .rdata1        (rdata1),
    .rdata2        (rdata2)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            wen;
    logic [AW-1:0] rd;
    logic [XW-1:0] data;
  } wr_t;

  wr_t          exp_q[$];
  int           n_cmp = 0;
  int           n_bad = 0;
  int           mptr  = 0;   // reference round-robin pointer
  logic [N-1:0] last_ready;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Drive one cycle of stimulus, check the grant against the reference and
  // queue the write expected to appear on the regfile port after the edge.
  task automatic cycle(input logic [N-1:0] v, input logic [N*AW-1:0] rds,
                       input logic [N*XW-1:0] ds, input logic h,
                       input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                       input logic [XW-1:0] d1, input logic [XW-1:0] d2);
    int           g;
    logic [N-1:0] exp_rdy;
    wr_t          w;
    @(negedge clk);
    wb.req_valid = v; wb.req_rd = rds; wb.req_data = ds; hold = h;
    rs1 = a1; rs2 = a2; rf_rdata1 = d1; rf_rdata2 = d2;
    g = -1;
    if (!h) begin
      for (int k = 0; k < N; k++)
        if (g < 0 && v[(mptr + k) % N]) g = (mptr + k) % N;
    end
    exp_rdy = '0; w.wen = 1'b0; w.rd = '0; w.data = '0;
    if (g >= 0) begin
      exp_rdy[g] = 1'b1;
      w.rd   = rds[g*AW +: AW];
      w.data = ds[g*XW +: XW];
      w.wen  = (w.rd != 0);
      mptr   = (g + 1) % N;
    end
    #1;
    last_ready = wb.req_ready;
    $display("cyc t=%0t valid=%b hold=%b ready=%b exp_ready=%b", $time, v, h, wb.req_ready, exp_rdy);
    check("req_ready", 64'(wb.req_ready), 64'(exp_rdy));
    exp_q.push_back(w);
  endtask

  task automatic rand_cycle();
    logic [N*AW-1:0] rds;
    logic [N*XW-1:0] ds;
    for (int i = 0; i < N; i++) begin
      rds[i*AW +: AW] = AW'($urandom_range(0, 7));
      ds[i*XW +: XW]  = $urandom();
    end
    cycle(N'($urandom_range(0, (1 << N) - 1)), rds, ds, ($urandom_range(0, 7) == 0),
          AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)), $urandom(), $urandom());
  endtask

  // Monitor: after each edge the regfile port reflects the oldest queued write.
  initial begin : monitor
    wr_t           w;
    logic [XW-1:0] e1, e2;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        w = exp_q.pop_front();
        check("rf_wEn", 64'(rf_wEn), 64'(w.wen));
        if (w.wen) begin
          check("rf_rd", 64'(rf_rd), 64'(w.rd));
          check("rf_write_data", 64'(rf_write_data), 64'(w.data));
        end
        e1 = (w.wen && w.rd == rs1 && rs1 != 0) ? w.data : rf_rdata1;
        e2 = (w.wen && w.rd == rs2 && rs2 != 0) ? w.data : rf_rdata2;
        check("rdata1", 64'(rdata1), 64'(e1));
        check("rdata2", 64'(rdata2), 64'(e2));
      end
    end
  end

  initial begin : stim
    int              cnt[N];
    logic [N*AW-1:0] rds;
    logic [N*XW-1:0] ds;

    wb.req_valid = '0; wb.req_rd = '0; wb.req_data = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset_rf_wEn", 64'(rf_wEn), 64'd0);
    check("reset_rf_rd", 64'(rf_rd), 64'd0);
    check("reset_rf_write_data", 64'(rf_write_data), 64'd0);
    wb.req_valid = 3'b111;
    #1;
    check("reset_ready", 64'(wb.req_ready), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("release_no_grant", 64'(wb.req_ready), 64'd0);
    @(posedge clk);

    // Fairness: all valid for 6 cycles -> 0,1,2,0,1,2
    for (int i = 0; i < N; i++) cnt[i] = 0;
    for (int c = 0; c < 6; c++) begin
      for (int i = 0; i < N; i++) begin
        rds[i*AW +: AW] = AW'(i + 1);
        ds[i*XW +: XW]  = 32'h100 * (c + 1) + i;
      end
      cycle(3'b111, rds, ds, 1'b0, '0, '0, 32'h0, 32'h0);
      for (int i = 0; i < N; i++) if (last_ready[i]) cnt[i]++;
    end
    for (int i = 0; i < N; i++) check("fair_count", 64'(cnt[i]), 64'd2);

    // Single request from requester 0
    rds = '0; ds = '0;
    rds[0 +: AW] = 5'd5; ds[0 +: XW] = 32'hDEAD_BEEF;
    cycle(3'b001, rds, ds, 1'b0, 5'd5, 5'd3, 32'h1111, 32'h2222);

    // x0 write from requester 1: accepted, never written, pointer moves to 2
    rds = '0; ds = '0;
    ds[XW +: XW] = 32'h1234;
    cycle(3'b010, rds, ds, 1'b0, 5'd0, 5'd0, 32'h0, 32'h0);
    rds = {5'd9, 5'd8, 5'd6}; ds = {32'hC, 32'hB, 32'hA};
    cycle(3'b111, rds, ds, 1'b0, '0, '0, 32'h0, 32'h0);

    // Bypass: rd=7 in flight while the regfile still returns old data
    rds = '0; ds = '0;
    rds[0 +: AW] = 5'd7; ds[0 +: XW] = 32'hA5A5;
    cycle(3'b001, rds, ds, 1'b0, 5'd7, 5'd7, 32'h0BAD, 32'h0BAD);
    cycle(3'b001, rds, ds, 1'b0, 5'd0, 5'd7, 32'h0, 32'h0BAD);

    // Hold for 3 cycles, then resume from the same pointer
    rds = {5'd3, 5'd2, 5'd1}; ds = {32'h33, 32'h22, 32'h11};
    for (int c = 0; c < 3; c++) cycle(3'b011, rds, ds, 1'b1, '0, '0, 32'h0, 32'h0);
    cycle(3'b011, rds, ds, 1'b0, 5'd1, 5'd2, 32'h0, 32'h0);

    // Randomized traffic
    for (int c = 0; c < 300; c++) rand_cycle();

    // Asynchronous reset mid-cycle with everything requesting
    @(posedge clk);
    #3;
    wb.req_valid = 3'b111;
    rst_n = 1'b0;
    #1;
    check("midreset_ready", 64'(wb.req_ready), 64'd0);
    check("midreset_rf_wEn", 64'(rf_wEn), 64'd0);
    check("midreset_rf_rd", 64'(rf_rd), 64'd0);
    mptr = 0;
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rerelease_no_grant", 64'(wb.req_ready), 64'd0);
    @(posedge clk);

    for (int c = 0; c < 100; c++) rand_cycle();
    rds = '0; ds = '0;
    repeat (3) cycle('0, rds, ds, 1'b0, '0, '0, 32'h0, 32'h0);
    @(posedge clk);
    #2;
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
